// File: rtl/mem_responder_if.sv
// Request/response handshake bundles for the data-memory port.
// mem_req_if: a/be/d/we + valid/ready; mem_resp_if: data + valid/ready.
interface mem_req_if;
  logic        valid;
  logic        ready;
  logic [31:0] a;
  logic [3:0]  be;
  logic [31:0] d;
  logic        we;

  modport master (
    output valid, a, be, d, we,
    input  ready
  );
  modport slave (
    input  valid, a, be, d, we,
    output ready
  );
endinterface

interface mem_resp_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (
    output valid, data,
    input  ready
  );
  modport slave (
    input  valid, data,
    output ready
  );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: in-order word array with fixed-latency responses.
// Ports: clk, rst (async, active-low), mem_req (slave), mem_resp (master).
module mem_responder #(
  parameter int    DEPTH      = 4096,
  parameter int    LATENCY    = 1,
  parameter int    RESP_DEPTH = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic       clk,
  input  logic       rst,
  mem_req_if.slave   mem_req,
  mem_resp_if.master mem_resp
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (RESP_DEPTH > 1) ?
                      $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [31:0]   r_mem  [DEPTH];
  logic [31:0]   r_fifo [RESP_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_fcnt;
  logic [CW-1:0] r_out;

  logic [AW-1:0] w_idx;
  logic          w_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_rdata;
  logic [31:0]   w_pdata;
  logic          w_unused;

  assign w_idx    = mem_req.a[AW+1:2];
  assign w_unused = ^{mem_req.a[31:AW+2],
                      mem_req.a[1:0]};

  // Credit check only; independent of valid.
  assign mem_req.ready = (r_out < CW'(RESP_DEPTH));
  assign w_acc   = mem_req.valid && mem_req.ready;

  assign w_empty = (r_fcnt == '0);
  assign w_full  = (r_fcnt == CW'(RESP_DEPTH));
  assign mem_resp.valid = !w_empty;
  assign mem_resp.data  = r_fifo[r_rp];
  assign w_pop   = mem_resp.valid && mem_resp.ready;

  // Read sees the array before this edge's write,
  // i.e. every earlier accepted store.
  assign w_rdata = mem_req.we ? 32'h0 : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_acc && mem_req.we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_req.be[i]) begin
          r_mem[w_idx][8*i +: 8] <= mem_req.d[8*i +: 8];
        end
      end
    end
  end

  if (LATENCY == 1) begin : g_nopipe
    assign w_push  = w_acc;
    assign w_pdata = w_rdata;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0] r_pv;
    logic [31:0]   r_pd [NS];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_acc;
        for (int i = 1; i < NS; i++) begin
          r_pv[i] <= r_pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_pd[0] <= w_rdata;
      for (int i = 1; i < NS; i++) begin
        r_pd[i] <= r_pd[i-1];
      end
    end

    assign w_push  = r_pv[NS-1];
    assign w_pdata = r_pd[NS-1];
  end

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(RESP_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_out  <= '0;
    end else begin
      if (w_push) begin
        r_wp <= f_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_inc(r_rp);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp] <= w_pdata;
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst)
    !(w_push && w_full));
  a_no_udf: assert property (
    @(posedge clk) disable iff (!rst)
    !(w_pop && w_empty));
  a_credit: assert property (
    @(posedge clk) disable iff (!rst)
    r_out <= CW'(RESP_DEPTH));
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder.
// Reference: word-array model plus in-order response queue.
module tb_mem_responder;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mem_req_if  req();
  mem_resp_if rsp();

  mem_responder #(
    .DEPTH(4096), .LATENCY(1),
    .RESP_DEPTH(RD), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(req), .mem_resp(rsp)
  );

  always #5 clk = ~clk;

  logic [31:0] mm [4096];
  logic [31:0] q[$];
  logic [31:0] popped[$];
  logic        last_acc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bemask(
    input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic cyc();
    logic [31:0] m;
    int ix;
    @(negedge clk);
    chk("req_ready", 32'(req.ready),
        32'(q.size() < RD));
    chk("resp_valid", 32'(rsp.valid),
        32'(q.size() != 0));
    if (rsp.valid && q.size() != 0)
      chk("resp_data", rsp.data, q[0]);
    last_acc = req.valid && req.ready;
    if (rsp.valid && rsp.ready) begin
      popped.push_back(rsp.data);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (last_acc) begin
      ix = int'(req.a[13:2]);
      if (req.we) begin
        m = bemask(req.be);
        mm[ix] = (mm[ix] & ~m) | (req.d & m);
        q.push_back(32'h0);
      end else begin
        q.push_back(mm[ix]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [3:0]  be,
                       input logic [31:0] d,
                       input logic        we);
    req.a = a; req.be = be;
    req.d = d; req.we = we;
    req.valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (last_acc) break;
    end
    chk("accept", 32'(last_acc), 32'd1);
    req.valid = 1'b0;
  endtask

  task automatic drain();
    rsp.ready = 1'b1;
    req.valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic pchk(input string tag,
                      input int i,
                      input logic [31:0] exp);
    if (popped.size() > i)
      chk(tag, popped[i], exp);
    else
      chk({tag, "_missing"}, 32'(popped.size()),
          32'(i + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req.valid = 1'b0;
    req.a = '0; req.be = '0;
    req.d = '0; req.we = 1'b0;
    rsp.ready = 1'b1;
    #2;
    chk("rst_ready", 32'(req.ready), 32'd1);
    chk("rst_valid", 32'(rsp.valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    popped.delete();
    issue(32'h100, 4'hF, 32'hDEADBEEF, 1'b1);
    issue(32'h100, 4'hF, 32'h0, 1'b0);
    drain();
    pchk("wr_resp", 0, 32'h0);
    pchk("rd_resp", 1, 32'hDEADBEEF);

    popped.delete();
    issue(32'h8, 4'hF, 32'h11223344, 1'b1);
    issue(32'hA, 4'b0110, 32'hAABBCCDD, 1'b1);
    issue(32'h8, 4'hF, 32'h0, 1'b0);
    drain();
    pchk("be_merge", 2, 32'h11BBCC44);

    popped.delete();
    issue(32'h0, 4'hF, 32'h5A5A5A5A, 1'b1);
    issue(32'h4000, 4'hF, 32'h0, 1'b0);
    drain();
    pchk("wrap", 1, 32'h5A5A5A5A);

    issue(32'h200, 4'hF, 32'hA0000001, 1'b1);
    issue(32'h204, 4'hF, 32'hB0000002, 1'b1);
    issue(32'h208, 4'hF, 32'hC0000003, 1'b1);
    drain();
    popped.delete();
    rsp.ready = 1'b0;
    issue(32'h200, 4'hF, 32'h0, 1'b0);
    issue(32'h204, 4'hF, 32'h0, 1'b0);
    req.a = 32'h208; req.we = 1'b0;
    req.valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_stall", 32'(last_acc), 32'd0);
    end
    rsp.ready = 1'b1;
    cyc();
    chk("bp_popcyc", 32'(last_acc), 32'd0);
    rsp.ready = 1'b0;
    cyc();
    chk("bp_accept", 32'(last_acc), 32'd1);
    req.valid = 1'b0;
    drain();
    pchk("bp_r0", 0, 32'hA0000001);
    pchk("bp_r1", 1, 32'hB0000002);
    pchk("bp_r2", 2, 32'hC0000003);

    popped.delete();
    rsp.ready = 1'b1;
    req.we = 1'b0;
    req.valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req.a = 32'h200 +
              32'($urandom_range(0, 2)) * 4;
      cyc();
      chk("stream_acc", 32'(last_acc), 32'd1);
    end
    req.valid = 1'b0;
    drain();
    chk("stream_n", 32'(popped.size()), 32'd20);

    rsp.ready = 1'b0;
    issue(32'h100, 4'hF, 32'h0, 1'b0);
    issue(32'h8, 4'hF, 32'h0, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req.ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp.valid), 32'd0);
    q.delete();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    popped.delete();
    rsp.ready = 1'b1;
    issue(32'h100, 4'hF, 32'h0, 1'b0);
    drain();
    pchk("post_rst", 0, 32'hDEADBEEF);

    for (int i = 0; i < 16; i++)
      issue(32'(i * 4), 4'hF, $urandom, 1'b1);
    drain();
    for (int k = 0; k < 400; k++) begin
      req.valid = 1'($urandom_range(0, 1));
      req.we    = 1'($urandom_range(0, 1));
      req.be    = 4'($urandom);
      req.d     = $urandom;
      req.a     = ($urandom & 32'hFFFFC000) |
                  (32'($urandom_range(0, 15)) << 2) |
                  ($urandom & 32'h3);
      rsp.ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
